// File: rtl/ar9331_pkg.sv
// Shared types and constants for the AR9331 receive-direction command path.
package ar9331_pkg;

  typedef enum logic [1:0] {
    H_IDLE,
    H_SETTLE,
    H_ACK
  } hs_state_t;

  typedef enum logic [2:0] {
    F_SYNC,
    F_ADDR,
    F_DHI,
    F_DLO,
    F_CSUM
  } frame_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ADDR    = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_cause_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/ar9331_byte_rx.sv
// Byte receiver: synchronizes the AR9331 strobe, waits for the data to settle,
// then captures one byte per 4-phase strobe/ack handshake.
module ar9331_byte_rx
  import ar9331_pkg::*;
#(
  parameter int SETTLE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  output logic       rx_ack,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  // Handshake: rx_strobe rises -> byte captured + rx_ack=1 -> rx_strobe falls
  // -> rx_ack=0. rx_data is only sampled after the strobe has settled.
  hs_state_t  hs_state, hs_state_n;
  logic [3:0] settle_cnt, settle_cnt_n;
  logic       sync_1, s_strobe;
  logic       capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1   <= 1'b0;
      s_strobe <= 1'b0;
    end else begin
      sync_1   <= rx_strobe;
      s_strobe <= sync_1;
    end
  end

  always_comb begin
    hs_state_n   = hs_state;
    settle_cnt_n = settle_cnt;
    capture      = 1'b0;
    case (hs_state)
      H_IDLE: begin
        if (s_strobe) begin
          hs_state_n   = H_SETTLE;
          settle_cnt_n = 4'd1;
        end
      end
      H_SETTLE: begin
        if (!s_strobe) begin
          hs_state_n = H_IDLE;
        end else if (settle_cnt == SETTLE_CNT) begin
          capture    = 1'b1;
          hs_state_n = H_ACK;
        end else begin
          settle_cnt_n = settle_cnt + 4'd1;
        end
      end
      H_ACK: begin
        if (!s_strobe) hs_state_n = H_IDLE;
      end
      default: hs_state_n = H_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_state   <= H_IDLE;
      settle_cnt <= 4'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      rx_ack     <= 1'b0;
    end else begin
      hs_state   <= hs_state_n;
      settle_cnt <= settle_cnt_n;
      byte_valid <= capture;
      rx_ack     <= (hs_state_n == H_ACK);
      if (capture) byte_data <= rx_data;
    end
  end

endmodule

// File: rtl/ar9331_cmd_rx.sv
// Frames received bytes (SYNC, ADDR, DHI, DLO, CSUM) into register-write
// strobes, rejecting bad addresses, bad checksums and stalled frames.
module ar9331_cmd_rx
  import ar9331_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         SETTLE    = 3,
  parameter int         TIMEOUT   = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  output logic        rx_ack,
  output logic        reg_ready,
  output logic [6:0]  reg_address,
  output logic [15:0] reg_data,
  output logic        frame_err,
  output logic [1:0]  err_cause
);

  localparam int             CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  IDLE_LIMIT = CW'(TIMEOUT - 1);

  logic         byte_valid;
  logic [7:0]   byte_data;

  frame_state_t frame_state, frame_state_n;
  logic [6:0]   addr_q, addr_n;
  logic [7:0]   dhi_q, dhi_n, dlo_q, dlo_n, csum_q, csum_n;
  logic [CW-1:0] idle_cnt;
  logic         good, err;
  err_cause_t   cause_n, cause_q;

  ar9331_byte_rx #(.SETTLE(SETTLE)) u_byte_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_strobe  (rx_strobe),
    .rx_ack     (rx_ack),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  always_comb begin
    frame_state_n = frame_state;
    addr_n        = addr_q;
    dhi_n         = dhi_q;
    dlo_n         = dlo_q;
    csum_n        = csum_q;
    good          = 1'b0;
    err           = 1'b0;
    cause_n       = ERR_NONE;
    if (byte_valid) begin
      case (frame_state)
        F_SYNC: if (byte_data == SYNC_BYTE) frame_state_n = F_ADDR;
        F_ADDR: begin
          if (byte_data[7]) begin
            err           = 1'b1;
            cause_n       = ERR_ADDR;
            frame_state_n = F_SYNC;
          end else begin
            addr_n        = byte_data[6:0];
            csum_n        = byte_data;
            frame_state_n = F_DHI;
          end
        end
        F_DHI: begin
          dhi_n         = byte_data;
          csum_n        = csum_q ^ byte_data;
          frame_state_n = F_DLO;
        end
        F_DLO: begin
          dlo_n         = byte_data;
          csum_n        = csum_q ^ byte_data;
          frame_state_n = F_CSUM;
        end
        F_CSUM: begin
          if (byte_data == csum_q) begin
            good = 1'b1;
          end else begin
            err     = 1'b1;
            cause_n = ERR_CSUM;
          end
          frame_state_n = F_SYNC;
        end
        default: frame_state_n = F_SYNC;
      endcase
    end else if (frame_state != F_SYNC && idle_cnt == IDLE_LIMIT) begin
      err           = 1'b1;
      cause_n       = ERR_TIMEOUT;
      frame_state_n = F_SYNC;
    end
  end

  // The byte cycle itself counts as the first elapsed cycle, so the error
  // pulse lands exactly TIMEOUT cycles after the last accepted byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (byte_valid) begin
      idle_cnt <= CW'(1);
    end else if (frame_state == F_SYNC) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_state <= F_SYNC;
      addr_q      <= 7'd0;
      dhi_q       <= 8'd0;
      dlo_q       <= 8'd0;
      csum_q      <= 8'd0;
      reg_ready   <= 1'b0;
      reg_address <= 7'd0;
      reg_data    <= 16'd0;
      frame_err   <= 1'b0;
      cause_q     <= ERR_NONE;
    end else begin
      frame_state <= frame_state_n;
      addr_q      <= addr_n;
      dhi_q       <= dhi_n;
      dlo_q       <= dlo_n;
      csum_q      <= csum_n;
      reg_ready   <= good;
      frame_err   <= err;
      if (good) begin
        reg_address <= addr_q;
        reg_data    <= {dhi_q, dlo_q};
      end
      if (err) cause_q <= cause_n;
    end
  end

  assign err_cause = cause_q;

endmodule

// File: doc/ar9331_cmd_rx.md
Name: ar9331_cmd_rx

Overview:
- Receive-direction counterpart of the FPGA-to-AR9331 byte streamer.
- Accepts bytes pushed by the AR9331 over the shared 8-bit parallel bus using a 4-phase strobe/ack handshake.
- Frames the bytes into register-write commands and emits one-cycle write strobes, for example to update DAC channel registers or ADC trigger settings.
- Sits on the 100 MHz core clock. The bus-turnaround mux outside this block selects receive mode.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- SETTLE, 3, core cycles that the synchronized strobe must stay high before data is sampled (range 1..15).
- TIMEOUT, 100000, maximum idle core cycles between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  core clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte driven by the AR9331; valid while rx_strobe is high.
- rx_strobe  in  1  AR9331 "byte valid" level; asynchronous to clk.
- rx_ack  out  1  byte-accepted level returned to the AR9331.
- reg_ready  out  1  one-cycle pulse: reg_address/reg_data hold a valid write.
- reg_address  out  7  register address of the last good frame.
- reg_data  out  16  register data of the last good frame.
- frame_err  out  1  one-cycle pulse on any frame rejection.
- err_cause  out  2  cause of the last error: 0 none, 1 bad address, 2 bad checksum, 3 timeout.

Behaviour:
- Reset values: rx_ack=0, reg_ready=0, frame_err=0, reg_address=0, reg_data=0, err_cause=0. Both FSMs go to their idle state. The 2-flop synchronizer is cleared.
- A reset asserted mid-byte or mid-frame discards the partial frame. rx_ack drops asynchronously.
- rx_strobe passes through a 2-flop synchronizer (s_strobe). rx_data is not synchronized. It is sampled only after s_strobe has been high for SETTLE consecutive cycles, which guarantees the data is stable.
- Handshake FSM states: H_IDLE, H_SETTLE, H_ACK.
  - H_IDLE: on s_strobe=1, load the settle counter and go to H_SETTLE.
  - H_SETTLE: if s_strobe falls, return to H_IDLE with no byte (glitch reject). When the counter reaches SETTLE, capture rx_data, pulse byte_valid internally for 1 cycle, set rx_ack=1, and go to H_ACK.
  - H_ACK: hold rx_ack=1 until s_strobe=0, then clear rx_ack and go to H_IDLE.
  - The AR9331 must not present a new byte until rx_ack is low. A strobe still high on re-entry to H_IDLE is treated as a new byte.
- Frame FSM states: F_SYNC, F_ADDR, F_DHI, F_DLO, F_CSUM. It advances only on byte_valid.
  - F_SYNC: a byte equal to SYNC_BYTE goes to F_ADDR. Any other byte is silently dropped (no error).
  - F_ADDR: bit7=1 causes frame_err with cause 1 and a return to F_SYNC. Otherwise latch addr[6:0] and init csum=byte.
  - F_DHI / F_DLO: latch the data byte and set csum ^= byte.
  - F_CSUM: if the byte equals csum, the frame is good. Otherwise frame_err with cause 2. Either way, go to F_SYNC.
- Good frame outputs:
  - reg_address and reg_data update in the cycle after the checksum byte is captured; reg_ready pulses in that same cycle.
  - Latency from the byte_valid pulse of the checksum byte to reg_ready is 1 cycle.
  - reg_address and reg_data hold their values until the next good frame.
- Timeout:
  - An idle counter runs in every state except F_SYNC and resets on each byte_valid.
  - When the counter reaches TIMEOUT-1: frame_err with cause 3, then F_SYNC. The counter width is $clog2(TIMEOUT+1).
  - If the timeout expiry and byte_valid land in the same cycle, byte_valid wins and there is no timeout.
- Error outputs: err_cause updates together with the frame_err pulse and holds until the next error.
- No back-pressure on reg_ready. A consumer must accept a write in 1 cycle. At most one write per 5 bytes is possible.

Decomposition:
- Package ar9331_pkg: typedefs for the handshake and frame state enums, err_cause enum (ERR_NONE, ERR_ADDR, ERR_CSUM, ERR_TIMEOUT), and the default SYNC_BYTE constant.
- Sub-module ar9331_byte_rx: synchronizer, settle counter and handshake FSM. It outputs byte_valid and a byte value.
- The frame FSM, checksum and timeout logic stay in the top.

Test Plan:
- After reset, send A5 12 0B B8 A1 with a 4-phase handshake (csum 12^0B^B8=A1) -> one reg_ready pulse; reg_address=7'h12, reg_data=16'h0BB8; rx_ack rises once per byte; frame_err never asserts.
- Send A5 12 0B B8 00 -> no reg_ready; frame_err pulses once with err_cause=2; a following good frame A5 05 00 10 15 -> reg_address=7'h05, reg_data=16'h0010.
- Send A5 then 80 -> frame_err with err_cause=1, immediately after the 80 byte; the frame FSM is back in F_SYNC.
- Send A5 12, then hold the bus idle for TIMEOUT+10 cycles (TIMEOUT=50 in the bench) -> frame_err with err_cause=3, exactly 50 cycles after the 12 byte; subsequent 0B B8 A1 produce no write.
- Pulse rx_strobe for 2 clk cycles (below SETTLE + sync) -> rx_ack stays 0 and no byte is consumed; a leading FF 3C before A5 ... -> garbage is dropped and the good frame is still decoded.
- Assert rst while in F_DLO with rx_ack=1 -> rx_ack drops without waiting for clk, and all outputs read 0; the next full frame decodes correctly.
